// File: rtl/stack_pkg.sv
// Shared types for the operand stack: operation encoding and FSM states.
package stack_pkg;

    localparam int unsigned STACK_OP_W = 3;

    typedef enum logic [STACK_OP_W-1:0] {
        OpNop  = 3'd0,
        OpPush = 3'd1,
        OpPop  = 3'd2,
        OpDup  = 3'd3,
        OpSwap = 3'd4,
        OpPop2 = 3'd5
    } stack_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdB,
        StWrA,
        StWrB,
        StDone
    } stack_state_e;

endpackage

// File: rtl/op_stack_if.sv
// Request/response bundle between the execute FSM (master) and the operand stack (slave).
interface op_stack_if
    import stack_pkg::*;
#(
    parameter int unsigned STACKDATA = 32,
    parameter int unsigned STACKSIZE = 16
) ();
    localparam int unsigned ADDRW = $clog2(STACKSIZE);

    logic                  trigger;
    logic [STACK_OP_W-1:0] op;
    logic [STACKDATA-1:0]  write_value;
    logic [STACKDATA-1:0]  read_value;
    logic [STACKDATA-1:0]  read_value2;
    logic                  done_out;
    logic                  error_out;
    logic                  busy;
    logic                  full;
    logic                  empty;
    logic [ADDRW:0]        depth;
    logic [ADDRW:0]        hwm;

    modport master (
        output trigger, op, write_value,
        input  read_value, read_value2, done_out, error_out, busy, full, empty, depth, hwm
    );

    modport slave (
        input  trigger, op, write_value,
        output read_value, read_value2, done_out, error_out, busy, full, empty, depth, hwm
    );

endinterface

// File: rtl/stack_ram.sv
// Single-port stack storage, synchronous read-first with one cycle of read latency.
module stack_ram #(
    parameter int unsigned DATAW = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned ADDRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ADDRW-1:0] addr,
    input  logic [DATAW-1:0] wdata,
    output logic [DATAW-1:0] rdata
);

    logic [DATAW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/op_stack.sv
// Operand stack with PUSH/POP/DUP/SWAP/POP2 over a single-port RAM.
// Define STACK_HWM_EN to build the high-water-mark register; otherwise hwm reads 0.
module op_stack
    import stack_pkg::*;
#(
    parameter int unsigned STACKDATA = 32,
    parameter int unsigned STACKSIZE = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    op_stack_if.slave bus
);

    localparam int unsigned ADDRW = $clog2(STACKSIZE);
    localparam logic [ADDRW:0] FULL_SP = (ADDRW + 1)'(STACKSIZE);

    stack_state_e         state_q, state_d;
    stack_op_e            op_q, op_d;
    logic [STACKDATA-1:0] wv_q, wv_d;
    logic [STACKDATA-1:0] tos_q, tos_d;
    logic [STACKDATA-1:0] rv_q, rv_d;
    logic [STACKDATA-1:0] rv2_q, rv2_d;
    logic [ADDRW:0]       sp_q, sp_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic                 ram_we;
    logic [ADDRW-1:0]     ram_addr;
    logic [STACKDATA-1:0] ram_wdata;
    logic [STACKDATA-1:0] ram_rdata;

    logic                 is_full, is_empty;
    logic [ADDRW-1:0]     sp_m1, sp_m2;
    logic                 req_valid, req_err;
    stack_state_e         req_state;

    assign is_full  = (sp_q == FULL_SP);
    assign is_empty = (sp_q == '0);
    assign sp_m1    = ADDRW'(sp_q - 1'b1);
    assign sp_m2    = ADDRW'(sp_q - 2'd2);

    // Over/underflow is judged against sp at the accepting edge; sp only moves in DONE.
    always_comb begin
        req_valid = 1'b1;
        req_err   = 1'b0;
        req_state = StRdA;
        case (bus.op)
            OpPush: begin
                req_err   = is_full;
                req_state = StWrA;
            end
            OpPop:          req_err = (sp_q < 1);
            OpDup:          req_err = is_full || is_empty;
            OpSwap, OpPop2: req_err = (sp_q < 2);
            default:        req_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wv_d      = wv_q;
        err_d     = err_q;
        tos_d     = tos_q;
        rv_d      = rv_q;
        rv2_d     = rv2_q;
        sp_d      = sp_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = sp_q[ADDRW-1:0];
        ram_wdata = wv_q;

        unique case (state_q)
            StIdle: begin
                if (bus.trigger && req_valid) begin
                    op_d    = stack_op_e'(bus.op);
                    wv_d    = bus.write_value;
                    err_d   = req_err;
                    state_d = req_state;
                end
            end
            StRdA: begin
                ram_addr = sp_m1;
                if (err_q || op_q == OpPop) begin
                    state_d = StDone;
                end else if (op_q == OpDup) begin
                    state_d = StWrA;
                end else begin
                    state_d = StRdB;
                end
            end
            StRdB: begin
                ram_addr = sp_m2;
                tos_d    = ram_rdata;
                state_d  = (op_q == OpSwap) ? StWrB_or_wra(1'b1) : StDone;
            end
            StWrA: begin
                state_d = StDone;
                if (!err_q) begin
                    ram_we = 1'b1;
                    case (op_q)
                        OpDup: begin
                            ram_wdata = ram_rdata;
                            tos_d     = ram_rdata;
                        end
                        OpSwap: begin
                            // Old next-on-stack (read in RD_B) becomes the new TOS.
                            ram_addr  = sp_m1;
                            ram_wdata = ram_rdata;
                            state_d   = StWrB;
                        end
                        default: ram_wdata = wv_q;
                    endcase
                end
            end
            StWrB: begin
                ram_we    = 1'b1;
                ram_addr  = sp_m2;
                ram_wdata = tos_q;
                state_d   = StDone;
            end
            StDone: begin
                state_d = StIdle;
                done_d  = 1'b1;
                error_d = err_q;
                if (!err_q) begin
                    case (op_q)
                        OpPush: sp_d = sp_q + 1'b1;
                        OpPop: begin
                            sp_d = sp_q - 1'b1;
                            rv_d = ram_rdata;
                        end
                        OpDup: begin
                            sp_d = sp_q + 1'b1;
                            rv_d = tos_q;
                        end
                        OpPop2: begin
                            sp_d  = sp_q - 2'd2;
                            rv_d  = tos_q;
                            rv2_d = ram_rdata;
                        end
                        default: sp_d = sp_q;
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
    end

    function automatic stack_state_e StWrB_or_wra(input logic swap);
        return swap ? StWrA : StDone;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OpNop;
            wv_q    <= '0;
            err_q   <= 1'b0;
            tos_q   <= '0;
            rv_q    <= '0;
            rv2_q   <= '0;
            sp_q    <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wv_q    <= wv_d;
            err_q   <= err_d;
            tos_q   <= tos_d;
            rv_q    <= rv_d;
            rv2_q   <= rv2_d;
            sp_q    <= sp_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

`ifdef STACK_HWM_EN
    logic [ADDRW:0] hwm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm_q <= '0;
        end else if (state_q == StDone && sp_d > hwm_q) begin
            hwm_q <= sp_d;
        end
    end

    assign bus.hwm = hwm_q;
`else
    assign bus.hwm = '0;
`endif

    stack_ram #(
        .DATAW (STACKDATA),
        .DEPTH (STACKSIZE),
        .ADDRW (ADDRW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bus.read_value  = rv_q;
    assign bus.read_value2 = rv2_q;
    assign bus.done_out    = done_q;
    assign bus.error_out   = error_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.full        = is_full;
    assign bus.empty       = is_empty;
    assign bus.depth       = sp_q;

endmodule
